// File: rtl/dino_pkg.sv
// Shared types, raster timing and colour table for the frame buffer scan-out path.
// Timing constants describe the 800x480 panel at a 33 MHz pixel clock.
package dino_pkg;

    localparam int COOR_WIDTH = 12;
    typedef logic [COOR_WIDTH-1:0] coord_t;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 190;
    localparam int H_SYNC   = 20;
    localparam int H_BP     = 46;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 22;
    localparam int V_SYNC   = 10;
    localparam int V_BP     = 13;

    // Index 0 is the background colour used for everything outside the frame window.
    localparam logic [23:0] PALETTE [8] = '{
        24'hF0F0F0, 24'h535353, 24'hFFFFFF, 24'hACACAC,
        24'hFF0000, 24'h00A000, 24'h0000FF, 24'hFFC000
    };

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
        logic in_win;
    } pix_t;

    localparam pix_t PIX_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1, in_win: 1'b0};

endpackage

// File: rtl/frame_scanout_video_timing.sv
// Free-running raster counters with raw (unregistered) syncs, active flag and vblank pulse.
// Raw outputs are combinational from h/v; no backpressure, the raster never stalls.
module video_timing
    import dino_pkg::*;
#(
    parameter int H_ACTIVE_P = H_ACTIVE,
    parameter int H_FP_P     = H_FP,
    parameter int H_SYNC_P   = H_SYNC,
    parameter int H_BP_P     = H_BP,
    parameter int V_ACTIVE_P = V_ACTIVE,
    parameter int V_FP_P     = V_FP,
    parameter int V_SYNC_P   = V_SYNC,
    parameter int V_BP_P     = V_BP
) (
    input  logic   clk_33m,
    input  logic   rst,
    output coord_t h,
    output coord_t v,
    output logic   active,
    output logic   hsync,
    output logic   vsync,
    output logic   vblank_start
);

    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE_P);
    localparam coord_t H_SS_C   = coord_t'(H_ACTIVE_P + H_FP_P);
    localparam coord_t H_SE_C   = coord_t'(H_ACTIVE_P + H_FP_P + H_SYNC_P);
    localparam coord_t H_LAST_C = coord_t'(H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE_P);
    localparam coord_t V_SS_C   = coord_t'(V_ACTIVE_P + V_FP_P);
    localparam coord_t V_SE_C   = coord_t'(V_ACTIVE_P + V_FP_P + V_SYNC_P);
    localparam coord_t V_LAST_C = coord_t'(V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P - 1);

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST_C) begin
            h <= '0;
            v <= (v == V_LAST_C) ? '0 : v + coord_t'(1);
        end else begin
            h <= h + coord_t'(1);
        end
    end

    assign active       = (h < H_ACT_C) && (v < V_ACT_C);
    assign hsync        = !((h >= H_SS_C) && (h < H_SE_C));
    assign vsync        = !((v >= V_SS_C) && (v < V_SE_C));
    assign vblank_start = (h == '0) && (v == V_ACT_C);

endmodule

// File: rtl/frame_scanout.sv
// Scans the front palette buffer through a scrolled window and drives the parallel RGB panel.
// Video outputs trail read_addr by RAM_LATENCY+1 cycles; no backpressure, the raster free-runs.
module frame_scanout
    import dino_pkg::*;
#(
    parameter int COOR_WIDTH   = dino_pkg::COOR_WIDTH,
    parameter int ADDR_WIDTH   = 19,
    parameter int FRAME_WIDTH  = 1280,
    parameter int FRAME_HEIGHT = 300,
    parameter int FRAME_Y0     = 90,
    parameter int RAM_LATENCY  = 2,
    parameter int H_ACTIVE_P   = H_ACTIVE,
    parameter int H_FP_P       = H_FP,
    parameter int H_SYNC_P     = H_SYNC,
    parameter int H_BP_P       = H_BP,
    parameter int V_ACTIVE_P   = V_ACTIVE,
    parameter int V_FP_P       = V_FP,
    parameter int V_SYNC_P     = V_SYNC,
    parameter int V_BP_P       = V_BP
) (
    input  logic                  clk_33m,
    input  logic                  rst,
    input  logic [COOR_WIDTH-1:0] scroll_x,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  front_buf,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [2:0]            read_palette,
    output logic [23:0]           rgb,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  vblank_start
);

    localparam int     V_TOTAL   = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;
    localparam coord_t H_ACT_C   = coord_t'(H_ACTIVE_P);
    localparam coord_t H_LAST_C  = coord_t'(H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
    localparam coord_t Y0_C      = coord_t'(FRAME_Y0);
    localparam coord_t Y0_PREV_C = coord_t'((FRAME_Y0 == 0) ? V_TOTAL - 1 : FRAME_Y0 - 1);
    localparam coord_t ROW_END_C = coord_t'(FRAME_Y0 + FRAME_HEIGHT);
    localparam coord_t ROW_LAST_C = coord_t'(FRAME_Y0 + FRAME_HEIGHT - 1);
    localparam logic [COOR_WIDTH-1:0] COL_LAST = COOR_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FRAME_WIDTH);

    coord_t                h, v;
    logic                  active_raw, hsync_raw, vsync_raw, vblank_raw;
    logic [COOR_WIDTH-1:0] s_lat, col;
    logic [ADDR_WIDTH-1:0] row_base;
    logic                  in_win, line_end, swap_now;
    pix_t                  pipe [RAM_LATENCY+1];
    logic [23:0]           pix_rgb;

    video_timing #(
        .H_ACTIVE_P(H_ACTIVE_P), .H_FP_P(H_FP_P), .H_SYNC_P(H_SYNC_P), .H_BP_P(H_BP_P),
        .V_ACTIVE_P(V_ACTIVE_P), .V_FP_P(V_FP_P), .V_SYNC_P(V_SYNC_P), .V_BP_P(V_BP_P)
    ) u_timing (
        .clk_33m      (clk_33m),
        .rst          (rst),
        .h            (h),
        .v            (v),
        .active       (active_raw),
        .hsync        (hsync_raw),
        .vsync        (vsync_raw),
        .vblank_start (vblank_raw)
    );

    assign in_win   = (h < H_ACT_C) && (v >= Y0_C) && (v < ROW_END_C);
    assign line_end = (h == H_LAST_C);
    assign swap_now = vblank_raw && swap_req;

    always_comb begin
        pix_rgb = '0;
        if (pipe[RAM_LATENCY].de)
            pix_rgb = pipe[RAM_LATENCY].in_win ? PALETTE[read_palette] : PALETTE[0];
    end

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            s_lat        <= '0;
            col          <= '0;
            row_base     <= '0;
            read_addr    <= '0;
            front_buf    <= 1'b0;
            swap_ack     <= 1'b0;
            vblank_start <= 1'b0;
            rgb          <= '0;
            de           <= 1'b0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            for (int i = 0; i <= RAM_LATENCY; i++) pipe[i] <= PIX_IDLE;
        end else begin
            // Scroll is only taken during vblank so a frame never tears mid-scan.
            if (vblank_raw) s_lat <= scroll_x;

            // col holds the column for the current h; reloaded for the next line at line end.
            if (line_end)
                col <= s_lat;
            else if (h < H_ACT_C)
                col <= (col == COL_LAST) ? '0 : col + COOR_WIDTH'(1);

            if (line_end) begin
                if (v == Y0_PREV_C)
                    row_base <= '0;
                else if ((v >= Y0_C) && (v < ROW_LAST_C))
                    row_base <= row_base + ROW_STEP;
            end

            read_addr <= in_win ? row_base + ADDR_WIDTH'(col) : '0;

            pipe[0] <= '{de: active_raw, hsync: hsync_raw, vsync: vsync_raw, in_win: in_win};
            for (int i = 1; i <= RAM_LATENCY; i++) pipe[i] <= pipe[i-1];

            de           <= pipe[RAM_LATENCY].de;
            hsync        <= pipe[RAM_LATENCY].hsync;
            vsync        <= pipe[RAM_LATENCY].vsync;
            rgb          <= pix_rgb;
            vblank_start <= vblank_raw;
            swap_ack     <= swap_now;
            if (swap_now) front_buf <= ~front_buf;
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// Scoreboard bench for frame_scanout on a shrunken raster so several frames fit in a short run.
module tb_frame_scanout;

    localparam int HA = 300, HF = 8, HS = 20, HB = 8;
    localparam int VA = 16,  VF = 2, VS = 10, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int FW = 1280, FH = 10, Y0 = 3;

    localparam logic [23:0] PAL [8] = '{
        24'hF0F0F0, 24'h535353, 24'hFFFFFF, 24'hACACAC,
        24'hFF0000, 24'h00A000, 24'h0000FF, 24'hFFC000
    };

    logic        clk_33m = 1'b0;
    logic        rst;
    logic [11:0] scroll_x;
    logic        swap_req;
    logic        swap_ack, front_buf, de, hsync, vsync, vblank_start;
    logic [18:0] read_addr;
    logic [2:0]  read_palette;
    logic [23:0] rgb;

    frame_scanout #(
        .ADDR_WIDTH(19), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .FRAME_Y0(Y0), .RAM_LATENCY(2),
        .H_ACTIVE_P(HA), .H_FP_P(HF), .H_SYNC_P(HS), .H_BP_P(HB),
        .V_ACTIVE_P(VA), .V_FP_P(VF), .V_SYNC_P(VS), .V_BP_P(VB)
    ) dut (
        .clk_33m      (clk_33m),
        .rst          (rst),
        .scroll_x     (scroll_x),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .front_buf    (front_buf),
        .read_addr    (read_addr),
        .read_palette (read_palette),
        .rgb          (rgb),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .vblank_start (vblank_start)
    );

    always #15 clk_33m = ~clk_33m;

    int n_cmp = 0, n_bad = 0;
    int k;
    int s_lat_m;
    logic fb_m;
    logic [18:0] a1, a2;
    logic [26:0] sb [$];
    int acks, de_cnt, hs_cnt, vs_cnt;
    bit rst_pend, did_rst, done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0; s_lat_m = 0; fb_m = 1'b0; a1 = '0; a2 = '0; acks = 0;
        sb.delete();
        repeat (3) sb.push_back({1'b0, 1'b1, 1'b1, 24'h0});
    endtask

    // Checks everything the DUT registered while processing raster position p = k-1.
    task automatic step();
        int p, h, v, fr, col;
        logic win, vb, ack, de_e, hs_e, vs_e;
        logic [18:0] ea;
        logic [23:0] rgb_e;
        logic [26:0] exp_v;
        p = k - 1; h = p % HT; v = (p / HT) % VT; fr = p / FT;
        win = (h < HA) && (v >= Y0) && (v < Y0 + FH);
        col = (s_lat_m + h) % FW;
        ea  = win ? 19'((v - Y0) * FW + col) : 19'd0;
        check("read_addr", 32'(read_addr), 32'(ea));

        vb  = (h == 0) && (v == VA);
        ack = vb && swap_req;
        if (ack) fb_m = ~fb_m;
        if (swap_ack) acks++;
        check("vblank_ack", 32'({vblank_start, swap_ack}), 32'({vb, ack}));
        check("front_buf", 32'(front_buf), 32'(fb_m));
        if (vb) s_lat_m = int'(scroll_x);

        if (fr == 0 && v == Y0 && h == 0)          check("row0_addr", 32'(read_addr), 32'd0);
        if (fr == 0 && v == Y0 + 1 && h == 0)      check("row1_addr", 32'(read_addr), 32'd1280);
        if (fr == 1 && v == Y0 + 1 && h == 279)    check("col_1279", 32'(read_addr), 32'd2559);
        if (fr == 1 && v == Y0 + 1 && h == 280)    check("col_wrap", 32'(read_addr), 32'd1280);
        if (fr == 1 && v == 12 && h == 0)          check("scroll_hold", 32'(read_addr), 32'd12520);
        if (fr == 2 && v == Y0 && h == 0)          check("scroll_new", 32'(read_addr), 32'd37);

        read_palette = a2[2:0];
        a2 = a1;
        a1 = read_addr;

        de_e  = (h < HA) && (v < VA);
        hs_e  = !((h >= HA + HF) && (h < HA + HF + HS));
        vs_e  = !((v >= VA + VF) && (v < VA + VF + VS));
        rgb_e = de_e ? (win ? PAL[ea[2:0]] : PAL[0]) : 24'h0;
        sb.push_back({de_e, hs_e, vs_e, rgb_e});
        exp_v = sb.pop_front();
        check("video", 32'({de, hsync, vsync, rgb}), 32'(exp_v));

        if (!did_rst && k >= 4 && k < 4 + FT) begin
            de_cnt += int'(de); hs_cnt += int'(!hsync); vs_cnt += int'(!vsync);
            if (k == 3 + FT) begin
                check("de_per_frame", 32'(de_cnt), 32'(HA * VA));
                check("hsync_low", 32'(hs_cnt), 32'(HS * VT));
                check("vsync_low", 32'(vs_cnt), 32'(VS * HT));
            end
        end
    endtask

    task automatic stimulus();
        int ch, cv, cf;
        ch = k % HT; cv = (k / HT) % VT; cf = k / FT;
        if (cf == 0 && cv == 5 && ch == 0)  swap_req = 1'b1;
        if (cf == 0 && cv == 12 && ch == 0) scroll_x = 12'd1000;
        if (cf == 1 && swap_ack)            swap_req = 1'b0;
        if (cf == 1 && cv == 10 && ch == 0) scroll_x = 12'd37;
        if (!did_rst && cf == 3 && cv == 8 && ch == 150) begin
            check("swap_count", 32'(acks), 32'd2);
            rst = 1'b1; rst_pend = 1'b1; did_rst = 1'b1;
        end
        if (did_rst && !rst_pend && k == 12 * HT) done = 1'b1;
    endtask

    initial begin
        rst = 1'b1; scroll_x = '0; swap_req = 1'b0; read_palette = '0;
        rst_pend = 1'b1; did_rst = 1'b0; done = 1'b0;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        k = 0;
        repeat (3) @(posedge clk_33m);
        for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
            @(negedge clk_33m);
            if (rst_pend) begin
                check("rst_addr", 32'(read_addr), 32'd0);
                check("rst_front", 32'(front_buf), 32'd0);
                check("rst_video", 32'({de, hsync, vsync, rgb}), 32'({1'b0, 1'b1, 1'b1, 24'h0}));
                check("rst_pulses", 32'({swap_ack, vblank_start}), 32'd0);
                model_reset();
                read_palette = '0;
                rst = 1'b0;
                rst_pend = 1'b0;
            end else begin
                k++;
                step();
                stimulus();
            end
        end
        if (!done) check("cycle_budget", 32'd0, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
